// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode and FSM encodings, instruction field positions and a
// sign-extension helper shared by the multi-cycle core.
package cpu_pkg;

   typedef enum logic [3:0] {
      OP_NOP  = 4'd0,
      OP_ADD  = 4'd1,
      OP_SUB  = 4'd2,
      OP_AND  = 4'd3,
      OP_OR   = 4'd4,
      OP_XOR  = 4'd5,
      OP_NOT  = 4'd6,
      OP_SHL  = 4'd7,
      OP_SHR  = 4'd8,
      OP_LD   = 4'd9,
      OP_ST   = 4'd10,
      OP_BEQ  = 4'd11,
      OP_JMP  = 4'd12,
      OP_LDI  = 4'd13,
      OP_HALT = 4'd14,
      OP_ILL  = 4'd15
   } opcode_e;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_e;

   localparam int unsigned OP_LSB  = 12;
   localparam int unsigned RA_LSB  = 9;
   localparam int unsigned RB_LSB  = 6;
   localparam int unsigned RD_LSB  = 3;
   localparam int unsigned IMM6_W  = 6;
   localparam int unsigned IMM9_W  = 9;
   localparam int unsigned IMM12_W = 12;

   // Sign-extends the low `width` bits of val to 32 bits.
   function automatic logic [31:0] sext(input logic [11:0] val, input int unsigned width);
      logic [31:0] t;
      t = {20'b0, val} << (32 - width);
      return $signed(t) >>> (32 - width);
   endfunction

endpackage

// File: rtl/mc_regfile.sv
// mc_regfile: 8 x DW general-purpose registers, two asynchronous read ports,
// one synchronous write port, R0 hardwired to zero, synchronous active-low clear.
module mc_regfile
   import cpu_pkg::*;
#(
   parameter int unsigned DW = 16
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic [2:0]    ra_addr_i,
   output logic [DW-1:0] ra_data_o,
   input  logic [2:0]    rb_addr_i,
   output logic [DW-1:0] rb_data_o,
   input  logic          we_i,
   input  logic [2:0]    wa_i,
   input  logic [DW-1:0] wd_i
);

   logic [DW-1:0] regs_q [8];

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < 8; i++) regs_q[i] <= '0;
      end else if (we_i && (wa_i != 3'd0)) begin
         regs_q[wa_i] <= wd_i;
      end
   end

   assign ra_data_o = (ra_addr_i == 3'd0) ? '0 : regs_q[ra_addr_i];
   assign rb_data_o = (rb_addr_i == 3'd0) ? '0 : regs_q[rb_addr_i];

endmodule

// File: rtl/mc_cpu_core.sv
// mc_cpu_core: multi-cycle 16-bit-instruction core (fetch/decode/exec/mem/wb)
// with req/ack data memory. Define ILLEGAL_TRAP_EN to trap opcode 15 into HALT.
module mc_cpu_core
   import cpu_pkg::*;
#(
   parameter int unsigned DW  = 16,
   parameter int unsigned AW  = 8,
   parameter int unsigned DAW = 8
) (
   input  logic           clk,
   input  logic           rst,
   output logic [AW-1:0]  imem_addr,
   input  logic [15:0]    imem_rdata,
   output logic           dmem_req,
   output logic           dmem_we,
   output logic [DAW-1:0] dmem_addr,
   output logic [DW-1:0]  dmem_wdata,
   input  logic [DW-1:0]  dmem_rdata,
   input  logic           dmem_ack,
   output logic           retire,
   output logic           halted,
   output logic           illegal
);

   localparam int unsigned SHW = $clog2(DW);

   state_e         state_q, state_d;
   logic [AW-1:0]  pc_q, pc_d;
   logic [15:0]    ir_q, ir_d;
   logic [DW-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;

   opcode_e        op;
   logic [2:0]     ra, rb, rd;
   logic [DW-1:0]  imm6_s, imm9_s, rf_a, rf_b;
   logic [AW-1:0]  br_off;
   logic           rf_we;
   logic [2:0]     rf_wa;

`ifdef ILLEGAL_TRAP_EN
   logic illegal_q, illegal_d;
   assign illegal = illegal_q;
`else
   assign illegal = 1'b0;
`endif

   assign op     = opcode_e'(ir_q[OP_LSB +: 4]);
   assign ra     = ir_q[RA_LSB +: 3];
   assign rb     = ir_q[RB_LSB +: 3];
   assign rd     = ir_q[RD_LSB +: 3];
   assign imm6_s = DW'(sext(12'(ir_q[IMM6_W-1:0]), IMM6_W));
   assign imm9_s = DW'(sext(12'(ir_q[IMM9_W-1:0]), IMM9_W));
   assign br_off = AW'(sext(12'(ir_q[IMM6_W-1:0]), IMM6_W));

   mc_regfile #(.DW(DW)) u_regfile (
      .clk_i     (clk),
      .rst_ni    (rst),
      .ra_addr_i (ra),
      .ra_data_o (rf_a),
      .rb_addr_i (rb),
      .rb_data_o (rf_b),
      .we_i      (rf_we),
      .wa_i      (rf_wa),
      .wd_i      (res_q)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_FETCH;
         pc_q    <= '0;
         ir_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
      end
   end

`ifdef ILLEGAL_TRAP_EN
   always_ff @(posedge clk) begin
      if (!rst) illegal_q <= 1'b0;
      else      illegal_q <= illegal_d;
   end
`endif

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      rf_we   = 1'b0;
      rf_wa   = rd;
      retire  = 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_d = illegal_q;
`endif
      case (state_q)
         S_FETCH: begin
            ir_d    = imem_rdata;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            a_d     = rf_a;
            b_d     = rf_b;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            state_d = S_WB;
            case (op)
               OP_ADD: res_d = a_q + b_q;
               OP_SUB: res_d = a_q - b_q;
               OP_AND: res_d = a_q & b_q;
               OP_OR:  res_d = a_q | b_q;
               OP_XOR: res_d = a_q ^ b_q;
               OP_NOT: res_d = ~a_q;
               OP_SHL: res_d = a_q << b_q[SHW-1:0];
               OP_SHR: res_d = a_q >> b_q[SHW-1:0];
               OP_LDI: res_d = imm9_s;
               OP_LD, OP_ST: begin
                  res_d   = a_q + imm6_s;
                  state_d = S_MEM;
               end
               // Control transfers retire straight from EXEC, skipping WB.
               OP_BEQ: begin
                  pc_d    = (a_q == b_q) ? pc_q + 1'b1 + br_off : pc_q + 1'b1;
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
               OP_JMP: begin
                  pc_d    = AW'(ir_q[IMM12_W-1:0]);
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
               OP_HALT: state_d = S_HALT;
`ifdef ILLEGAL_TRAP_EN
               OP_ILL: begin
                  illegal_d = 1'b1;
                  state_d   = S_HALT;
               end
`endif
               default: ;
            endcase
         end
         S_MEM: begin
            if (dmem_ack) begin
               if (op == OP_LD) res_d = dmem_rdata;
               state_d = S_WB;
            end
         end
         S_WB: begin
            pc_d    = pc_q + 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
            case (op)
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR: rf_we = 1'b1;
               OP_LD: begin
                  rf_we = 1'b1;
                  rf_wa = rb;
               end
               OP_LDI: begin
                  rf_we = 1'b1;
                  rf_wa = ra;
               end
               default: ;
            endcase
         end
         S_HALT: ;
         default: state_d = S_FETCH;
      endcase
   end

   assign imem_addr  = pc_q;
   assign dmem_req   = (state_q == S_MEM);
   assign dmem_we    = (op == OP_ST);
   assign dmem_addr  = res_q[DAW-1:0];
   assign dmem_wdata = b_q;
   assign halted     = (state_q == S_HALT);

endmodule

// File: tb/tb_mc_cpu_core.sv
// tb_mc_cpu_core: directed programs for mc_cpu_core; expected retires and memory
// accesses are queued by the stimulus and popped by an independent monitor.
module tb_mc_cpu_core;

   localparam int unsigned DW  = 16;
   localparam int unsigned AW  = 8;
   localparam int unsigned DAW = 8;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic [AW-1:0]  imem_addr;
   logic [15:0]    imem_rdata;
   logic           dmem_req, dmem_we;
   logic [DAW-1:0] dmem_addr;
   logic [DW-1:0]  dmem_wdata;
   logic [DW-1:0]  dmem_rdata;
   logic           dmem_ack;
   logic           retire, halted, illegal;

   logic [15:0]    rom  [256];
   logic [DW-1:0]  dmem [256];
   int             ack_delay = 0;
   int             wcnt = 0;
   int             n_tests = 0;
   int             n_fail = 0;
   bit             sb_on = 1'b0;

   typedef struct {int pc; int gap;} ret_t;
   typedef struct {bit we; int addr; int wdata; int hold;} mem_t;
   ret_t ret_q[$];
   mem_t mem_q[$];

   mc_cpu_core #(.DW(DW), .AW(AW), .DAW(DAW)) dut (
      .clk        (clk),
      .rst        (rst),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_rdata (dmem_rdata),
      .dmem_ack   (dmem_ack),
      .retire     (retire),
      .halted     (halted),
      .illegal    (illegal)
   );

   always #5 clk = ~clk;
   assign imem_rdata = rom[imem_addr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_ret(input int pc, input int gap);
      ret_t r;
      r.pc = pc; r.gap = gap;
      ret_q.push_back(r);
   endtask

   task automatic push_mem(input bit we, input int addr, input int wdata, input int hold);
      mem_t m;
      m.we = we; m.addr = addr; m.wdata = wdata; m.hold = hold;
      mem_q.push_back(m);
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) begin
         rom[i]  = 16'hE000;
         dmem[i] = '0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst   = 1'b0;
      sb_on = 1'b0;
      repeat (2) @(negedge clk);
      rst   = 1'b1;
      sb_on = 1'b1;
   endtask

   task automatic drain(input string name, input int budget);
      int n = 0;
      while ((ret_q.size() != 0 || mem_q.size() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      n_tests++;
      if (ret_q.size() != 0 || mem_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s: %0d retires and %0d accesses still outstanding, expected 0",
                  name, ret_q.size(), mem_q.size());
         ret_q.delete();
         mem_q.delete();
      end
   endtask

   task automatic wait_halt(input string name);
      int n = 0;
      while (halted !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      #2;
      check(name, halted, 1'b1);
   endtask

   // Data memory responder: ack after ack_delay wait states.
   initial begin
      dmem_ack   = 1'b0;
      dmem_rdata = '0;
      forever begin
         @(negedge clk);
         if (dmem_req === 1'b1) begin
            if (wcnt >= ack_delay) begin
               dmem_ack = 1'b1;
               if (dmem_we) dmem[dmem_addr] = dmem_wdata;
               else         dmem_rdata = dmem[dmem_addr];
               wcnt = 0;
            end else begin
               dmem_ack = 1'b0;
               wcnt++;
            end
         end else begin
            dmem_ack = 1'b0;
            wcnt = 0;
         end
      end
   end

   // Monitor: pops expected retires and memory accesses as the DUT presents them.
   initial begin
      int   gap;
      int   hold;
      ret_t r;
      mem_t m;
      gap  = 0;
      hold = 0;
      forever begin
         @(negedge clk);
         #2;
         if (rst !== 1'b1) begin
            gap  = 0;
            hold = 0;
         end else begin
            gap++;
            if (dmem_req === 1'b1) hold++;
            if (sb_on && dmem_req === 1'b1) begin
               if (mem_q.size() == 0) begin
                  if (dmem_ack === 1'b1) begin
                     n_tests++;
                     n_fail++;
                     $display("FAIL mem_unexpected: access at addr 0x%0h, expected none", dmem_addr);
                  end
               end else begin
                  check("mem_addr", dmem_addr, mem_q[0].addr);
                  if (dmem_ack === 1'b1) begin
                     m = mem_q.pop_front();
                     check("mem_we", dmem_we, m.we);
                     if (m.we) check("mem_wdata", dmem_wdata, m.wdata);
                     check("mem_req_hold", hold, m.hold);
                  end
               end
            end
            if (dmem_req !== 1'b1 || dmem_ack === 1'b1) hold = 0;
            if (retire === 1'b1) begin
               if (sb_on) begin
                  if (ret_q.size() == 0) begin
                     n_tests++;
                     n_fail++;
                     $display("FAIL retire_unexpected: pc 0x%0h, expected no retire", imem_addr);
                  end else begin
                     r = ret_q.pop_front();
                     check("retire_pc", imem_addr, r.pc);
                     check("retire_gap", gap, r.gap);
                  end
               end
               gap = 0;
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int gap_a [16];
      int n;
      gap_a = '{4, 4, 4, 8, 8, 8, 8, 4, 4, 8, 8, 4, 4, 8, 4, 8};

      // ALU, LDI and wait-stated memory program.
      clear_mem();
      ack_delay = 3;
      rom[0]  = 16'hD205; rom[1]  = 16'hD5FD; rom[2]  = 16'h1298; rom[3]  = 16'hA04A;
      rom[4]  = 16'h910A; rom[5]  = 16'hA10B; rom[6]  = 16'hA0CC; rom[7]  = 16'h22A8;
      rom[8]  = 16'h7370; rom[9]  = 16'hA18D; rom[10] = 16'hA37F; rom[11] = 16'h5478;
      rom[12] = 16'h8E78; rom[13] = 16'hA1CE; rom[14] = 16'h1240; rom[15] = 16'hA00F;
      rom[16] = 16'hE000;
      repeat (3) @(negedge clk);
      #2;
      check("rst_pc", imem_addr, 0);
      check("rst_req", dmem_req, 1'b0);
      check("rst_retire", retire, 1'b0);
      check("rst_halted", halted, 1'b0);
      check("rst_illegal", illegal, 1'b0);
      for (int i = 0; i < 16; i++) push_ret(i, gap_a[i]);
      push_mem(1'b1, 10, 5, 4);
      push_mem(1'b0, 10, 0, 4);
      push_mem(1'b1, 11, 5, 4);
      push_mem(1'b1, 12, 2, 4);
      push_mem(1'b1, 13, 16'h0500, 4);
      push_mem(1'b1, 4, 8, 4);
      push_mem(1'b1, 14, 16'h07FF, 4);
      push_mem(1'b1, 15, 0, 4);
      @(negedge clk);
      rst   = 1'b1;
      sb_on = 1'b1;
      drain("prog_alu_mem", 400);
      wait_halt("halt_reached");
      check("halt_illegal", illegal, 1'b0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #2;
         check("halt_pc_frozen", imem_addr, 16);
         check("halt_no_req", dmem_req, 1'b0);
      end

      // Branches, jumps and PC wrap.
      clear_mem();
      ack_delay = 0;
      rom[0] = 16'hD205; rom[1] = 16'hD403; rom[2] = 16'hC005; rom[5] = 16'hB282;
      rom[6] = 16'hB483; rom[10] = 16'hCFFF; rom[255] = 16'hD607;
      push_ret(0, 4); push_ret(1, 4); push_ret(2, 3); push_ret(5, 3);
      push_ret(6, 3); push_ret(10, 3); push_ret(255, 4); push_ret(0, 4);
      do_reset();
      drain("prog_branch", 100);
      sb_on = 1'b0;

      // BEQ self-loop at pc 4.
      rom[0] = 16'hC004;
      rom[4] = 16'hB27F;
      push_ret(0, 3);
      for (int i = 0; i < 4; i++) push_ret(4, 3);
      do_reset();
      drain("prog_selfloop", 60);
      sb_on = 1'b0;

      // Reset while a store waits for ack; registers must come back cleared.
      clear_mem();
      ack_delay = 0;
      rom[0] = 16'hA054; rom[1] = 16'hD205; rom[2] = 16'hA055; rom[3] = 16'hE000;
      push_ret(0, 5); push_ret(1, 4);
      push_mem(1'b1, 20, 0, 1);
      do_reset();
      drain("prog_pre_abort", 60);
      ack_delay = 1000;
      n = 0;
      while (dmem_req !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("abort_req_seen", dmem_req, 1'b1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #2;
      check("abort_req_drop", dmem_req, 1'b0);
      check("abort_pc", imem_addr, 0);
      check("abort_retire", retire, 1'b0);
      check("abort_halted", halted, 1'b0);
      ack_delay = 0;
      push_ret(0, 5); push_ret(1, 4); push_ret(2, 5);
      push_mem(1'b1, 20, 0, 1);
      push_mem(1'b1, 21, 5, 1);
      @(negedge clk);
      rst = 1'b1;
      drain("prog_post_abort", 80);
      wait_halt("abort_halt");

      // Opcode 15.
      clear_mem();
      rom[0] = 16'hD205; rom[1] = 16'hF3FF; rom[2] = 16'hA05E; rom[3] = 16'hA1DF;
      rom[4] = 16'hE000;
`ifdef ILLEGAL_TRAP_EN
      push_ret(0, 4);
      do_reset();
      drain("prog_illegal", 60);
      wait_halt("illegal_halt");
      check("illegal_flag", illegal, 1'b1);
      check("illegal_pc", imem_addr, 1);
      repeat (5) @(negedge clk);
      #2;
      check("illegal_sticky", illegal, 1'b1);
`else
      push_ret(0, 4); push_ret(1, 4); push_ret(2, 5); push_ret(3, 5);
      push_mem(1'b1, 30, 5, 1);
      push_mem(1'b1, 31, 0, 1);
      do_reset();
      drain("prog_illegal_nop", 80);
      wait_halt("illegal_nop_halt");
      check("illegal_flag", illegal, 1'b0);
      check("illegal_nop_pc", imem_addr, 4);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mc_cpu_core.md
Name: mc_cpu_core

Overview:
- Parametrised multi-cycle successor to the single-cycle 16-bit core.
- 16-bit fixed instruction format; data width DW; 8 GPRs.
- Explicit FSM: fetch/decode/execute/memory/writeback.
- Adds branches, jumps, load-immediate, HALT, and a req/ack data-memory handshake tolerating wait states.
- Sits between an asynchronous-read instruction ROM and a handshaked data RAM.

Parameters:
DW, 16, data/register width; legal range 12..32.
AW, 8, PC and imem address width; PC wraps mod 2^AW.
DAW, 8, data memory address width; effective address = low DAW bits of sum.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-low reset
imem_addr  out  AW  instruction address (= pc)
imem_rdata  in  16  instruction, combinational from imem_addr
dmem_req  out  1  data access request
dmem_we  out  1  1=store, 0=load; valid while dmem_req
dmem_addr  out  DAW  data address
dmem_wdata  out  DW  store data
dmem_rdata  in  DW  load data, sampled on the cycle dmem_ack=1
dmem_ack  in  1  access complete
retire  out  1  one-cycle pulse per completed instruction
halted  out  1  high in HALT state
illegal  out  1  sticky illegal-opcode flag (ILLEGAL_TRAP_EN only, else tied 0)

Behaviour:
- Reset (rst=0 at a clk edge): pc=0, state=FETCH, all GPRs=0, ir=0, dmem_req=0, retire=0, halted=0, illegal=0. Applies mid-MEM too: dmem_req drops on the next cycle and the pending access is abandoned.
- Encoding: op[15:12], ra[11:9], rb[8:6], rd[5:3], imm6[5:0], imm9[8:0], imm12[11:0].
- R0 reads as 0; writes to R0 are discarded.
- Opcodes:
  - 0 NOP.
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR: rd=ra op rb.
  - 6 NOT: rd=~ra.
  - 7 SHL, 8 SHR (logical): shift ra by rb[$clog2(DW)-1:0].
  - 9 LD: rb=M[ra+sext(imm6)].
  - 10 ST: M[ra+sext(imm6)]=rb.
  - 11 BEQ: if ra==rb, pc=pc+1+sext(imm6), else pc+1.
  - 12 JMP: pc=imm12[AW-1:0].
  - 13 LDI: ra=sext(imm9).
  - 14 HALT.
  - 15 illegal.
- Arithmetic is mod 2^DW, with no flags.
- FSM:
  - FETCH: ir<=imem_rdata.
  - DECODE: latch A=R[ra], B=R[rb].
  - EXEC: latch ALU result/address. BEQ/JMP load pc, pulse retire, go to FETCH. HALT goes to HALT. LD/ST go to MEM. All others go to WB.
  - MEM: dmem_req=1 with addr/we/wdata stable until dmem_ack. On ack: load captures dmem_rdata, then go to WB. dmem_req deasserts the cycle after ack.
  - WB: register write (none for NOP/ST), pc<=pc+1, retire=1, go to FETCH.
  - HALT: absorbing until reset; halted=1; no memory activity.
- Latency:
  - ALU/LDI/NOP: 4 cycles.
  - BEQ/JMP: 3 cycles.
  - LD/ST: 5 cycles plus wait states (ack in the first MEM cycle means zero wait).
- dmem_ack is ignored outside MEM.
- Register reads in DECODE see all prior writebacks, because instructions never overlap.

Optional Feature:
- ILLEGAL_TRAP_EN defined: op 15 at EXEC sets illegal=1 (sticky until reset) and goes to HALT with no retire.
- Undefined: op 15 executes as NOP and illegal is constant 0.

Decomposition:
- Package cpu_pkg holds:
  - opcode enum (4-bit);
  - FSM state enum;
  - field bit-position localparams;
  - sext helper function.
- One sub-module: mc_regfile with 8xDW entries, 2 async read ports, 1 sync write port, R0 hardwired 0, synchronous active-low clear.

Test Plan:
- LDI R1,5; LDI R2,-3; ADD R3,R1,R2 -> R3=2. Retire pulses at cycles 4, 8, 12 after reset release.
- ST R1 to [R0+10], then LD R4,[R0+10], with ack delayed 3 cycles -> dmem_req held 4 cycles, dmem_addr=10, dmem_wdata=5. R4=5; LD retires 8 cycles after its fetch.
- BEQ R1,R1,-1 at pc=4 -> pc returns to 4 each iteration (self-loop); BEQ with unequal operands -> pc=5; 3-cycle cadence.
- JMP 0xFFF with AW=8 -> pc=0xFF. Following WB at 0xFF -> pc wraps to 0.
- HALT -> halted=1 and pc frozen for 20 cycles. Reset pulse during MEM with ack withheld -> dmem_req=0 next cycle, pc=0, GPRs=0.
- Op 15 -> with ILLEGAL_TRAP_EN: illegal=1, halted=1. Without: pc increments and no register changes.
